atomic_counter_reader: RTL



---
 rtl/atomic_counter_reader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/atomic_counter_reader.sv
// Initiator for the atomic 64-bit counter read: atomic low-word read, then frozen high-word read,
// with per-transaction timeout, 64-bit reassembly and delta against the previous snapshot.
module atomic_counter_reader #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [63:0] value_o,
  output logic [63:0] delta_o,
  output logic        timeout_o,
  output logic [15:0] sample_cnt_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WAIT_LO,
    S_REQ_HI,
    S_WAIT_HI,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   value_q, value_d;
  logic [63:0]   delta_q, delta_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          atomic_q, atomic_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          tmo;
  logic [63:0]   snap;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      lo_q      <= '0;
      value_q   <= '0;
      delta_q   <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      atomic_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      lo_q      <= lo_d;
      value_q   <= value_d;
      delta_q   <= delta_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      atomic_q  <= atomic_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, datapath updates, and state-decoded outputs registered one step ahead.
  // value_q doubles as the previous snapshot for the delta.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    lo_d      = lo_q;
    value_d   = value_q;
    delta_d   = delta_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    tmo       = (tcnt_q == TO_LAST);
    snap      = {count_i, lo_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_REQ_LO;
      end
      S_REQ_LO: begin
        state_d = S_WAIT_LO;
        tcnt_d  = '0;
      end
      S_WAIT_LO: begin
        if (ack_i) begin
          lo_d    = count_i;
          state_d = S_REQ_HI;
        end else if (tmo) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_REQ_HI: begin
        state_d = S_WAIT_HI;
        tcnt_d  = '0;
      end
      S_WAIT_HI: begin
        if (ack_i) begin
          value_d = snap;
          delta_d = snap - value_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_DONE;
        end else if (tmo) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = start_i ? S_REQ_LO : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d    = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
    atomic_d = (state_d == S_REQ_LO);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    valid_d  = (state_d == S_DONE);
  end

  assign req_o        = req_q;
  assign atomic_o     = atomic_q;
  assign busy_o       = busy_q;
  assign valid_o      = valid_q;
  assign timeout_o    = timeout_q;
  assign value_o      = value_q;
  assign delta_o      = delta_q;
  assign sample_cnt_o = cnt_q;

endmodule
